// File: rtl/dot_product_ctrl.sv
// ---------------------------------------------------------------------------
// dot_product_ctrl
//
// Runs one signed dot product over two external sync-read memories (A and B)
// that share a single element address. On start it reads elements
// 0..N-1, one per cycle. It multiplies each returned pair and adds the
// product into a ripple-carry accumulator built from full-adder cells. The
// sum is then offered on a valid/ready result port. Only one job can be in
// flight at a time.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   start         job request, only looked at while idle
//   len           element count, captured with start (clamped to LEN_MAX)
//   busy          high whenever the controller is not idle
//   mem_rd_en     read strobe to both memories
//   mem_addr      element index shared by both memories
//   a_data        A element, valid the cycle after a read strobe
//   b_data        B element, valid the cycle after a read strobe
//   result        signed dot product (wraps modulo 2^ACC_W)
//   result_valid  result available
//   result_ready  consumer accepts the result
// ---------------------------------------------------------------------------
module dot_product_ctrl #(
    parameter int DATA_W  = 8,
    parameter int LEN_MAX = 16,
    parameter int ACC_W   = 20,
    localparam int ADDR_W = $clog2(LEN_MAX),
    localparam int LEN_W  = $clog2(LEN_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ADDR_W-1:0]  last_addr_reg;
    // Delayed read strobe: high exactly when a_data/b_data carry a fresh pair.
    logic               rd_d_reg;

    logic [LEN_W-1:0]          len_clamped;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]          prod_ext;
    logic [ACC_W-1:0]          sum;

    assign len_clamped = (len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : len;

    assign prod     = $signed(a_data) * $signed(b_data);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Ripple-carry adder acc_reg + prod_ext. Every bit except the MSB is a
    // full-adder cell with a carry out. The MSB carry out is dropped because
    // the sum wraps modulo 2^ACC_W.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_W - 1; gi++) begin : g_fa
            logic cin;
            logic cout;
            if (gi == 0) begin : g_lsb
                assign cin = 1'b0;
            end else begin : g_chain
                assign cin = g_fa[gi-1].cout;
            end
            assign sum[gi] = acc_reg[gi] ^ prod_ext[gi] ^ cin;
            assign cout    = (acc_reg[gi] & prod_ext[gi]) |
                             (acc_reg[gi] & cin) |
                             (prod_ext[gi] & cin);
        end
    endgenerate

    assign sum[ACC_W-1] = acc_reg[ACC_W-1] ^ prod_ext[ACC_W-1] ^ g_fa[ACC_W-2].cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            last_addr_reg <= '0;
            rd_d_reg      <= 1'b0;
            busy          <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
        end else begin
            rd_d_reg <= mem_rd_en;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len == '0) begin
                            // Empty job: report zero without touching memory.
                            result       <= '0;
                            result_valid <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            last_addr_reg <= ADDR_W'(len_clamped - 1'b1);
                            acc_reg       <= '0;
                            mem_addr      <= '0;
                            mem_rd_en     <= 1'b1;
                            state_reg     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_d_reg) begin
                        acc_reg <= sum;
                    end
                    if (mem_addr == last_addr_reg) begin
                        mem_rd_en <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The pair for the last address arrives now. The read
                    // issued before it guarantees rd_d_reg is high here.
                    acc_reg      <= sum;
                    result       <= sum;
                    result_valid <= 1'b1;
                    state_reg    <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dot_product_ctrl
//
// Self-checking bench for dot_product_ctrl. Two sync-read memories are modelled
// here. Their outputs carry random junk on cycles that follow no read strobe.
// The reference result is plain integer arithmetic over the stored vectors.
//
// Edge numbering: E0 is the edge that samples start. "Valid rises at Ek"
// means the value present at edge Ek is the first high one.
// ---------------------------------------------------------------------------
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic [19:0] result;
    logic        result_valid;
    logic        result_ready;

    int total = 0;
    int bad   = 0;

    logic signed [7:0] mem_a [16];
    logic signed [7:0] mem_b [16];
    int addr_q[$];

    dot_product_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .a_data       (a_data),
        .b_data       (b_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Sync-read memories. Every strobed address is logged for later checks.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            a_data <= mem_a[mem_addr];
            b_data <= mem_b[mem_addr];
            addr_q.push_back(int'(mem_addr));
        end else begin
            a_data <= 8'($urandom);
            b_data <= 8'($urandom);
        end
    end

    function automatic logic [19:0] ref_dot(input int n);
        int s;
        int m;
        s = 0;
        m = (n > 16) ? 16 : n;
        for (int i = 0; i < m; i++) begin
            s += int'(mem_a[i]) * int'(mem_b[i]);
        end
        return 20'(s);
    endfunction

    function automatic int exp_rise(input int n);
        return (n == 0) ? 1 : (((n > 16) ? 16 : n) + 2);
    endfunction

    function automatic bit addrs_in_order(input int n);
        bit ok;
        ok = (addr_q.size() == n);
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] != i) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
    endtask

    // Issue one job and wait, within a bounded time, for result_valid.
    // It leaves the bench at the negedge where valid was first seen.
    task automatic run_job(input int n, output int rise, output logic [19:0] res);
        int k;
        addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        len   = 5'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (result_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        rise = k + 1;
        res  = result;
    endtask

    // Accept the pending result, then report valid and busy one edge later.
    task automatic accept(output logic v_after, output logic b_after);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_after = result_valid;
        b_after = busy;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] outs;
        rst = 1'b1;
        start = 1'b1;
        len = 5'd4;
        result_ready = 1'b0;
        #1;
        outs = {busy, mem_rd_en, mem_addr, result, result_valid};
        total++;
        if (outs !== 28'd0) begin
            bad++;
            $display("FAIL reset_async outs=%h required=0", outs);
        end
        repeat (3) @(negedge clk);
        outs = {busy, mem_rd_en, mem_addr, result, result_valid};
        total++;
        if (outs !== 28'd0) begin
            bad++;
            $display("FAIL reset_held outs=%h required=0", outs);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b required=0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int rise;
        logic [19:0] res;
        logic v, b;
        fill_random();
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        run_job(4, rise, res);
        total++;
        if (res !== 20'd70) begin
            bad++;
            $display("FAIL basic_result got=%0d required=70", res);
        end
        total++;
        if (rise !== 6) begin
            bad++;
            $display("FAIL basic_latency got=E%0d required=E6", rise);
        end
        total++;
        if (addrs_in_order(4) !== 1'b1) begin
            bad++;
            $display("FAIL basic_addrs count=%0d required=4 in order 0..3", addr_q.size());
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got=%b required=1", busy);
        end
        accept(v, b);
        total++;
        if ({v, b} !== 2'b00) begin
            bad++;
            $display("FAIL basic_accept valid,busy=%b%b required=00", v, b);
        end
        $display("test_basic len=4 result=%0d rise=E%0d", res, rise);
    endtask

    task automatic test_extremes();
        int rise;
        logic [19:0] res;
        logic v, b;
        mem_a[0] = -8'sd128; mem_b[0] = -8'sd128;
        mem_a[1] = -8'sd128; mem_b[1] = 8'sd127;
        run_job(2, rise, res);
        total++;
        if (res !== 20'd128) begin
            bad++;
            $display("FAIL extreme_mix got=%0d required=128", res);
        end
        accept(v, b);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = -8'sd128;
            mem_b[i] = -8'sd128;
        end
        run_job(16, rise, res);
        total++;
        if (res !== 20'd262144) begin
            bad++;
            $display("FAIL extreme_full got=%0d required=262144", res);
        end
        total++;
        if (rise !== 18) begin
            bad++;
            $display("FAIL extreme_latency got=E%0d required=E18", rise);
        end
        accept(v, b);
        $display("test_extremes done");
    endtask

    task automatic test_len_zero();
        int rise;
        logic [19:0] res;
        logic v, b;
        fill_random();
        run_job(0, rise, res);
        total++;
        if (res !== 20'd0) begin
            bad++;
            $display("FAIL zero_result got=%0d required=0", res);
        end
        total++;
        if (rise !== 1) begin
            bad++;
            $display("FAIL zero_latency got=E%0d required=E1", rise);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_busy got=%b required=1", busy);
        end
        accept(v, b);
        total++;
        if ({v, b} !== 2'b00) begin
            bad++;
            $display("FAIL zero_accept valid,busy=%b%b required=00", v, b);
        end
        total++;
        if (addr_q.size() !== 0) begin
            bad++;
            $display("FAIL zero_reads got=%0d required=0", addr_q.size());
        end
        $display("test_len_zero result=%0d rise=E%0d", res, rise);
    endtask

    task automatic test_start_ignored();
        int k;
        int reads_seen;
        bit stable;
        logic [19:0] held;
        logic [19:0] expv;
        fill_random();
        expv = ref_dot(5);
        addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        len = 5'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;          // restart attempt while reading
        len = 5'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        k = 0;
        while (result_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (result !== expv) begin
            bad++;
            $display("FAIL ign_result got=%0d required=%0d", result, expv);
        end
        total++;
        if (addrs_in_order(5) !== 1'b1) begin
            bad++;
            $display("FAIL ign_addrs count=%0d required=5", addr_q.size());
        end
        held = result;
        reads_seen = addr_q.size();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== held || busy !== 1'b1) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1 || addr_q.size() !== reads_seen) begin
            bad++;
            $display("FAIL ign_hold stable=%b reads=%0d required stable=1 reads=%0d",
                     stable, addr_q.size(), reads_seen);
        end
        start = 1'b1;          // start in the accepting DONE cycle is ignored too
        len = 5'd4;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b0;
        total++;
        if ({result_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL ign_accept valid,busy=%b%b required=00", result_valid, busy);
        end
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || mem_rd_en !== 1'b0) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1 || result !== held) begin
            bad++;
            $display("FAIL ign_no_restart idle=%b result=%0d required idle=1 result=%0d",
                     stable, result, held);
        end
        $display("test_start_ignored result=%0d", held);
    endtask

    task automatic test_reset_mid_run();
        logic [27:0] outs;
        int rise;
        logic [19:0] res;
        logic v, b;
        bit quiet;
        fill_random();
        @(negedge clk);
        start = 1'b1;
        len = 5'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        outs = {busy, mem_rd_en, mem_addr, result, result_valid};
        total++;
        if (outs !== 28'd0) begin
            bad++;
            $display("FAIL midrun_reset outs=%h required=0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL midrun_discard quiet=%b required=1", quiet);
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        run_job(4, rise, res);
        total++;
        if (res !== 20'd70 || rise !== 6) begin
            bad++;
            $display("FAIL midrun_rerun result=%0d rise=E%0d required 70 at E6", res, rise);
        end
        accept(v, b);
        $display("test_reset_mid_run rerun=%0d", res);
    endtask

    task automatic test_clamp();
        int rise;
        logic [19:0] res;
        logic [19:0] expv;
        logic v, b;
        fill_random();
        expv = ref_dot(20);
        run_job(20, rise, res);
        total++;
        if (res !== expv) begin
            bad++;
            $display("FAIL clamp_result got=%0d required=%0d", res, expv);
        end
        total++;
        if (addrs_in_order(16) !== 1'b1) begin
            bad++;
            $display("FAIL clamp_addrs count=%0d required=16 in order 0..15", addr_q.size());
        end
        total++;
        if (rise !== 18) begin
            bad++;
            $display("FAIL clamp_latency got=E%0d required=E18", rise);
        end
        accept(v, b);
        $display("test_clamp len=20 result=%0d", res);
    endtask

    task automatic test_random_jobs();
        int n, rise, m;
        logic [19:0] res;
        logic [19:0] expv;
        logic v, b;
        for (int j = 0; j < 10; j++) begin
            fill_random();
            n = $urandom_range(0, 20);
            m = (n > 16) ? 16 : n;
            expv = ref_dot(n);
            run_job(n, rise, res);
            total++;
            if (res !== expv || rise !== exp_rise(n) || addrs_in_order(m) !== 1'b1) begin
                bad++;
                $display("FAIL rand_job%0d len=%0d result=%0d rise=E%0d reads=%0d required %0d at E%0d reads=%0d",
                         j, n, res, rise, addr_q.size(), expv, exp_rise(n), m);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept(v, b);
            total++;
            if ({v, b} !== 2'b00) begin
                bad++;
                $display("FAIL rand_accept%0d valid,busy=%b%b required=00", j, v, b);
            end
            $display("rand job %0d len=%0d result=%0d", j, n, res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_clamp();
        test_random_jobs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
